// File: rtl/mantissa_normalizer_pkg.sv
// Shared definitions for the post-add normalization stage: FSM state
// encoding and the single/double precision significand/exponent widths.
package mantissa_normalizer_pkg;

   localparam int SW_SP = 24;
   localparam int EW_SP = 8;
   localparam int SW_DP = 53;
   localparam int EW_DP = 11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHECK   = 2'd1,
      ST_SHIFT_L = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/mantissa_normalizer_if.sv
// Request/result bundle between the adder stage (master) and the
// normalizer (slave); signal names follow the FP adder datapath.
interface mantissa_normalizer_if #(
   parameter int SW = mantissa_normalizer_pkg::SW_SP,
   parameter int EW = mantissa_normalizer_pkg::EW_SP
);
   logic          start;
   logic [SW:0]   Add_Sub_Result;
   logic [EW-1:0] Exp_in;
   logic [SW-1:0] Sgf_out;
   logic [EW-1:0] Exp_out;
   logic          busy;
   logic          ready;
   logic          overflow;
   logic          underflow;

   modport master (
      output start, Add_Sub_Result, Exp_in,
      input  Sgf_out, Exp_out, busy, ready, overflow, underflow
   );

   modport slave (
      input  start, Add_Sub_Result, Exp_in,
      output Sgf_out, Exp_out, busy, ready, overflow, underflow
   );
endinterface

// File: rtl/mantissa_normalizer_fsm_ctrl.sv
// Normalizer control: state register plus next-state logic that turns
// datapath status into load/shift/flush strobes.
module mantissa_normalizer_fsm_ctrl
   import mantissa_normalizer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_zero,
   input  logic i_carry,
   input  logic i_hidden,
   input  logic i_exp_le1,
   output logic o_load,
   output logic o_shift_r,
   output logic o_shift_l,
   output logic o_flush,
   output logic o_uflow,
   output logic o_busy,
   output logic o_ready
);

   state_t r_state;
   state_t w_next;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Next state and datapath strobes.
   always_comb begin
      w_next    = r_state;
      o_load    = 1'b0;
      o_shift_r = 1'b0;
      o_shift_l = 1'b0;
      o_flush   = 1'b0;
      o_uflow   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               o_load = 1'b1;
               w_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (i_zero) begin
               o_flush = 1'b1;
               w_next  = ST_DONE;
            end else if (i_carry) begin
               o_shift_r = 1'b1;
               w_next    = ST_DONE;
            end else if (i_hidden) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_SHIFT_L;
            end
         end
         ST_SHIFT_L: begin
            if (i_hidden) begin
               w_next = ST_DONE;
            end else if (i_exp_le1) begin
               // One more shift would take the exponent below 1.
               o_flush = 1'b1;
               o_uflow = 1'b1;
               w_next  = ST_DONE;
            end else begin
               o_shift_l = 1'b1;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign o_busy  = (r_state != ST_IDLE);
   assign o_ready = (r_state == ST_DONE);

endmodule

// File: rtl/mantissa_normalizer.sv
// Post-add normalization: fixes carry-out with one right shift, strips
// leading zeros one bit per cycle, flags exponent overflow/underflow.
module mantissa_normalizer
   import mantissa_normalizer_pkg::*;
#(
   parameter int SW = SW_SP,
   parameter int EW = EW_SP
) (
   input  logic                  clk,
   input  logic                  rst,
   mantissa_normalizer_if.slave  bus
);

   localparam logic [EW-1:0] EXP_MAX = '1;
   localparam logic [EW-1:0] EXP_OVF = EXP_MAX - 1'b1;

   logic [SW:0]   r_sgf;
   logic [EW-1:0] r_exp;
   logic          r_ovf;
   logic          r_unf;
   logic [SW-1:0] r_sgf_hold;
   logic [EW-1:0] r_exp_hold;

   logic w_load, w_shift_r, w_shift_l, w_flush, w_uflow, w_busy, w_ready;
   logic w_zero, w_carry, w_hidden, w_exp_le1;

   assign w_zero    = (r_sgf == '0);
   assign w_carry   = r_sgf[SW];
   assign w_hidden  = r_sgf[SW-1];
   assign w_exp_le1 = (r_exp <= EW'(1));

   mantissa_normalizer_fsm_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .i_start   (bus.start),
      .i_zero    (w_zero),
      .i_carry   (w_carry),
      .i_hidden  (w_hidden),
      .i_exp_le1 (w_exp_le1),
      .o_load    (w_load),
      .o_shift_r (w_shift_r),
      .o_shift_l (w_shift_l),
      .o_flush   (w_flush),
      .o_uflow   (w_uflow),
      .o_busy    (w_busy),
      .o_ready   (w_ready)
   );

   // Working significand/exponent and flags, driven by controller strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sgf <= '0;
         r_exp <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (w_load) begin
         r_sgf <= bus.Add_Sub_Result;
         r_exp <= bus.Exp_in;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (w_flush) begin
         r_sgf <= '0;
         r_exp <= '0;
         if (w_uflow) r_unf <= 1'b1;
      end else if (w_shift_r) begin
         // LSB dropped here; rounding happens in the next stage.
         r_sgf <= r_sgf >> 1;
         if (r_exp >= EXP_OVF) begin
            r_exp <= EXP_MAX;
            r_ovf <= 1'b1;
         end else begin
            r_exp <= r_exp + 1'b1;
         end
      end else if (w_shift_l) begin
         r_sgf <= r_sgf << 1;
         r_exp <= r_exp - 1'b1;
      end
   end

   // Capture the result on ready so outputs stay stable while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sgf_hold <= '0;
         r_exp_hold <= '0;
      end else if (w_ready) begin
         r_sgf_hold <= r_sgf[SW-1:0];
         r_exp_hold <= r_exp;
      end
   end

   assign bus.Sgf_out   = w_ready ? r_sgf[SW-1:0] : r_sgf_hold;
   assign bus.Exp_out   = w_ready ? r_exp : r_exp_hold;
   assign bus.busy      = w_busy;
   assign bus.ready     = w_ready;
   assign bus.overflow  = r_ovf;
   assign bus.underflow = r_unf;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed bench for mantissa_normalizer (SW=24, EW=8).
module tb_mantissa_normalizer;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mantissa_normalizer_if #(.SW(24), .EW(8)) bus ();

   mantissa_normalizer #(.SW(24), .EW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request; return start-to-ready latency (-1 on timeout)
   // and whether busy stayed high the whole time.
   task automatic do_op(input logic [24:0] a, input logic [7:0] e,
                        output int lat, output bit bsy);
      @(negedge clk);
      bus.start = 1'b1; bus.Add_Sub_Result = a; bus.Exp_in = e;
      @(negedge clk);
      bus.start = 1'b0;
      bsy = bus.busy;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (!bus.busy) bsy = 1'b0;
         if (bus.ready) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start = 1'b0; bus.Add_Sub_Result = '0; bus.Exp_in = '0;
      repeat (2) @(negedge clk);
      checks++; if (bus.Sgf_out !== 24'h0) begin errors++; $display("FAIL reset_sgf got %h exp 0", bus.Sgf_out); end
      checks++; if (bus.Exp_out !== 8'h0) begin errors++; $display("FAIL reset_exp got %h exp 0", bus.Exp_out); end
      checks++; if ({bus.busy, bus.ready, bus.overflow, bus.underflow} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl got %b exp 0000", {bus.busy, bus.ready, bus.overflow, bus.underflow}); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_carry();
      int lat; bit bsy;
      do_op(25'h1800000, 8'h80, lat, bsy);
      checks++; if (lat !== 1) begin errors++; $display("FAIL carry_lat got %0d exp 1", lat); end
      checks++; if (bus.Sgf_out !== 24'hC00000) begin errors++; $display("FAIL carry_sgf got %h exp c00000", bus.Sgf_out); end
      checks++; if (bus.Exp_out !== 8'h81) begin errors++; $display("FAIL carry_exp got %h exp 81", bus.Exp_out); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL carry_flags got %b exp 00", {bus.overflow, bus.underflow}); end
      @(negedge clk);
      checks++; if ({bus.ready, bus.busy} !== 2'b00) begin errors++; $display("FAIL carry_ready_pulse got %b exp 00", {bus.ready, bus.busy}); end
      checks++; if (bus.Sgf_out !== 24'hC00000) begin errors++; $display("FAIL carry_hold got %h exp c00000", bus.Sgf_out); end
   endtask

   task automatic test_normalized();
      int lat; bit bsy;
      do_op(25'h0C00000, 8'h10, lat, bsy);
      checks++; if (lat !== 1) begin errors++; $display("FAIL norm_lat got %0d exp 1", lat); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'hC00000, 8'h10}) begin
         errors++; $display("FAIL norm_res got %h/%h exp c00000/10", bus.Sgf_out, bus.Exp_out); end
   endtask

   task automatic test_shift3();
      int lat; bit bsy;
      do_op(25'h0100000, 8'h10, lat, bsy);
      checks++; if (lat !== 5) begin errors++; $display("FAIL shift3_lat got %0d exp 5", lat); end
      checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL shift3_busy got %b exp 1", bsy); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'h800000, 8'h0D}) begin
         errors++; $display("FAIL shift3_res got %h/%h exp 800000/0d", bus.Sgf_out, bus.Exp_out); end
   endtask

   task automatic test_underflow();
      int lat; bit bsy;
      do_op(25'h0000001, 8'h03, lat, bsy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL uflow_lat got %0d exp 4", lat); end
      checks++; if ({bus.underflow, bus.overflow} !== 2'b10) begin errors++; $display("FAIL uflow_flags got %b exp 10", {bus.underflow, bus.overflow}); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== 32'h0) begin
         errors++; $display("FAIL uflow_res got %h/%h exp 0/0", bus.Sgf_out, bus.Exp_out); end
   endtask

   task automatic test_zero();
      int lat; bit bsy;
      do_op(25'h0, 8'h40, lat, bsy);
      checks++; if (lat !== 1) begin errors++; $display("FAIL zero_lat got %0d exp 1", lat); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== 32'h0) begin
         errors++; $display("FAIL zero_res got %h/%h exp 0/0", bus.Sgf_out, bus.Exp_out); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL zero_flags got %b exp 00", {bus.overflow, bus.underflow}); end
   endtask

   task automatic test_overflow();
      int lat; bit bsy;
      do_op(25'h1000000, 8'hFE, lat, bsy);
      checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_lat got %0d exp 1", lat); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'h800000, 8'hFF}) begin
         errors++; $display("FAIL ovf_res got %h/%h exp 800000/ff", bus.Sgf_out, bus.Exp_out); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b10) begin errors++; $display("FAIL ovf_flags got %b exp 10", {bus.overflow, bus.underflow}); end
   endtask

   task automatic test_max_shift();
      int lat; bit bsy;
      do_op(25'h0000001, 8'h80, lat, bsy);
      checks++; if (lat !== 25) begin errors++; $display("FAIL maxsh_lat got %0d exp 25", lat); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'h800000, 8'h69}) begin
         errors++; $display("FAIL maxsh_res got %h/%h exp 800000/69", bus.Sgf_out, bus.Exp_out); end
   endtask

   task automatic test_back_to_back();
      int lat; bit bsy;
      do_op(25'h0400000, 8'h20, lat, bsy);
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'h800000, 8'h1F}) begin
         errors++; $display("FAIL b2b_first got %h/%h exp 800000/1f", bus.Sgf_out, bus.Exp_out); end
      do_op(25'h1FFFFFF, 8'h20, lat, bsy);
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_lat got %0d exp 1", lat); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'hFFFFFF, 8'h21}) begin
         errors++; $display("FAIL b2b_second got %h/%h exp ffffff/21", bus.Sgf_out, bus.Exp_out); end
   endtask

   task automatic test_start_while_busy();
      int lat;
      int extra;
      @(negedge clk);
      bus.start = 1'b1; bus.Add_Sub_Result = 25'h0100000; bus.Exp_in = 8'h10;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.Add_Sub_Result = 25'h1800000; bus.Exp_in = 8'h80;
      @(negedge clk);
      bus.start = 1'b0;
      lat = -1;
      for (int i = 3; i <= 40; i++) begin
         @(negedge clk);
         if (bus.ready) begin lat = i; break; end
      end
      checks++; if (lat !== 5) begin errors++; $display("FAIL busy_start_lat got %0d exp 5", lat); end
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== {24'h800000, 8'h0D}) begin
         errors++; $display("FAIL busy_start_res got %h/%h exp 800000/0d", bus.Sgf_out, bus.Exp_out); end
      extra = 0;
      repeat (3) begin @(negedge clk); if (bus.busy || bus.ready) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_ghost got %0d exp 0", extra); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk);
      bus.start = 1'b1; bus.Add_Sub_Result = 25'h0000001; bus.Exp_in = 8'h80;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if ({bus.Sgf_out, bus.Exp_out} !== 32'h0) begin
         errors++; $display("FAIL rstmid_res got %h/%h exp 0/0", bus.Sgf_out, bus.Exp_out); end
      checks++; if ({bus.busy, bus.ready, bus.overflow, bus.underflow} !== 4'b0) begin
         errors++; $display("FAIL rstmid_ctl got %b exp 0000", {bus.busy, bus.ready, bus.overflow, bus.underflow}); end
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (30) begin @(negedge clk); if (bus.ready || bus.busy) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_noready got %0d exp 0", pulses); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_carry();
      test_normalized();
      test_shift3();
      test_underflow();
      test_zero();
      test_overflow();
      test_max_shift();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
